conv_window_sched: RTL and testbench



---
 rtl/conv_window_sched.sv | 197 +++++++++++++++++++
 tb/tb_conv_window_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// Window-fetch sequencer for the first conv layer: walks every kernel window of the picture and issues tap addresses.
// Optional build macro SCHED_STALL_CNT_EN enables the backpressure stall counter on stall_cycles.
module conv_window_sched #(
  parameter int unsigned LENGTH      = 60,
  parameter int unsigned HEIGHT      = 60,
  parameter int unsigned LENGTH_W    = 6,
  parameter int unsigned HEIGHT_W    = 6,
  parameter int unsigned FILTER_SIZE = 3,
  parameter int unsigned FILTER_W    = 2,
  parameter int unsigned STRIDE      = 4,
  parameter int unsigned WEIGHT_W    = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                out_ready,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   pic_addr,
  output logic [WEIGHT_W-1:0] weight_addr,
  output logic                data_valid,
  output logic                win_last,
  output logic                frame_done,
  output logic                busy,
  output logic [15:0]         win_count,
  output logic [15:0]         stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic                w_advance;
  logic                w_issue;
  logic                w_start_ok;
  logic [MEM_LAT-1:0]  w_vld_next;
  logic [MEM_LAT-1:0]  r_vld;
  logic [MEM_LAT-1:0]  r_last;

  logic [FILTER_W-1:0] r_row_off;
  logic [FILTER_W-1:0] r_col_off;
  logic [LENGTH_W-1:0] r_col_start;
  logic [HEIGHT_W-1:0] r_row_start;
  logic [WEIGHT_W-1:0] r_weight_addr;
  logic [ADDR_W-1:0]   r_pic_addr;
  logic [15:0]         r_win_count;
  logic                r_busy;
  logic                r_frame_done;

  logic [FILTER_W-1:0] w_row_off_n;
  logic [FILTER_W-1:0] w_col_off_n;
  logic [LENGTH_W-1:0] w_col_start_n;
  logic [HEIGHT_W-1:0] w_row_start_n;
  logic [WEIGHT_W-1:0] w_weight_n;
  logic [ADDR_W-1:0]   w_addr_n;

  logic w_row_end;
  logic w_col_end;
  logic w_win_last;
  logic w_cs_end;
  logic w_rs_end;
  logic w_frame_last;

  // Position of the current tap within its window and of the window within the picture
  assign w_row_end    = (r_row_off == FILTER_W'(FILTER_SIZE - 1));
  assign w_col_end    = (r_col_off == FILTER_W'(FILTER_SIZE - 1));
  assign w_win_last   = w_row_end & w_col_end;
  assign w_cs_end     = (32'(r_col_start) + STRIDE) > (LENGTH - FILTER_SIZE);
  assign w_rs_end     = (32'(r_row_start) + STRIDE) > (HEIGHT - FILTER_SIZE);
  assign w_frame_last = w_win_last & w_cs_end & w_rs_end;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_next = S_RUN;
        S_RUN:   if (w_issue && w_frame_last) w_state_next = S_DRAIN;
        S_DRAIN: if (w_vld_next == MEM_LAT'(0)) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // A held beat blocks the whole pipe; an empty output slot or an accepting PE lets it move
  always_comb begin
    w_advance  = 1'b0;
    w_issue    = 1'b0;
    w_start_ok = 1'b0;
    if (r_state == S_RUN || r_state == S_DRAIN) w_advance = ~r_vld[MEM_LAT-1] | out_ready;
    w_issue    = w_advance & (r_state == S_RUN) & ~abort;
    w_start_ok = (r_state == S_IDLE) & start & ~abort;
    w_vld_next = w_advance ? ((r_vld << 1) | MEM_LAT'(w_issue)) : r_vld;
  end

  // Next tap: row offset fastest, then column offset, then window origin
  always_comb begin
    w_row_off_n   = r_row_off + FILTER_W'(1);
    w_col_off_n   = r_col_off;
    w_col_start_n = r_col_start;
    w_row_start_n = r_row_start;
    w_weight_n    = r_weight_addr + WEIGHT_W'(1);
    if (w_row_end) begin
      w_row_off_n = '0;
      w_col_off_n = r_col_off + FILTER_W'(1);
      if (w_col_end) begin
        w_col_off_n = '0;
        w_weight_n  = '0;
        if (w_cs_end) begin
          w_col_start_n = '0;
          w_row_start_n = w_rs_end ? '0 : r_row_start + HEIGHT_W'(STRIDE);
        end else begin
          w_col_start_n = r_col_start + LENGTH_W'(STRIDE);
        end
      end
    end
    w_addr_n = (ADDR_W'(w_row_start_n) + ADDR_W'(w_row_off_n)) * ADDR_W'(LENGTH)
             + ADDR_W'(w_col_start_n) + ADDR_W'(w_col_off_n);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_vld         <= '0;
      r_last        <= '0;
      r_row_off     <= '0;
      r_col_off     <= '0;
      r_col_start   <= '0;
      r_row_start   <= '0;
      r_weight_addr <= '0;
      r_pic_addr    <= '0;
      r_win_count   <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_busy       <= (w_state_next == S_RUN) || (w_state_next == S_DRAIN);
      r_frame_done <= (w_state_next == S_DONE);
      if (abort) begin
        r_vld  <= '0;
        r_last <= '0;
      end else if (w_advance) begin
        r_vld  <= w_vld_next;
        r_last <= (r_last << 1) | MEM_LAT'(w_issue & w_win_last);
      end
      if (w_start_ok) begin
        r_row_off     <= '0;
        r_col_off     <= '0;
        r_col_start   <= '0;
        r_row_start   <= '0;
        r_weight_addr <= '0;
        r_pic_addr    <= '0;
        r_win_count   <= '0;
      end else if (w_issue) begin
        r_row_off     <= w_row_off_n;
        r_col_off     <= w_col_off_n;
        r_col_start   <= w_col_start_n;
        r_row_start   <= w_row_start_n;
        r_weight_addr <= w_weight_n;
        r_pic_addr    <= w_addr_n;
        if (w_win_last && r_win_count != 16'hFFFF) r_win_count <= r_win_count + 16'd1;
      end
    end
  end

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                                                      r_stall <= '0;
    else if (w_start_ok)                                             r_stall <= '0;
    else if (r_vld[MEM_LAT-1] && !out_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 16'd0;
`endif

  assign mem_en      = w_advance;
  assign pic_addr    = r_pic_addr;
  assign weight_addr = r_weight_addr;
  assign data_valid  = r_vld[MEM_LAT-1];
  assign win_last    = r_last[MEM_LAT-1];
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign win_count   = r_win_count;

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: default 60x60 instance plus a small 8x8 stride-2 instance,
// checked every cycle against a window-walk model computed from plain arithmetic.
module tb_conv_window_sched;

  localparam int TOTAL   = 2025;
  localparam int S_TOTAL = 81;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic        out_ready = 1'b1;
  logic        mem_en, data_valid, win_last, frame_done, busy;
  logic [11:0] pic_addr;
  logic [3:0]  weight_addr;
  logic [15:0] win_count, stall_cycles;

  logic        s_start = 1'b0;
  logic        s_mem_en, s_data_valid, s_win_last, s_frame_done, s_busy;
  logic [11:0] s_pic_addr;
  logic [3:0]  s_weight_addr;
  logic [15:0] s_win_count, s_stall_cycles;

  conv_window_sched u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .mem_en(mem_en), .pic_addr(pic_addr), .weight_addr(weight_addr), .data_valid(data_valid),
    .win_last(win_last), .frame_done(frame_done), .busy(busy), .win_count(win_count),
    .stall_cycles(stall_cycles)
  );

  conv_window_sched #(.LENGTH(8), .HEIGHT(8), .LENGTH_W(4), .HEIGHT_W(4), .STRIDE(2)) u_small (
    .clk_in(clk_in), .rst_n(rst_n), .start(s_start), .abort(1'b0), .out_ready(1'b1),
    .mem_en(s_mem_en), .pic_addr(s_pic_addr), .weight_addr(s_weight_addr), .data_valid(s_data_valid),
    .win_last(s_win_last), .frame_done(s_frame_done), .busy(s_busy), .win_count(s_win_count),
    .stall_cycles(s_stall_cycles)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Address of tap k of a frame: windows row-major, taps column by column, row offset fastest
  function automatic int exp_addr(input int k, input int len, input int fs, input int st);
    int wpr, w, t;
    wpr = (len - fs) / st + 1;
    w   = k / (fs * fs);
    t   = k % (fs * fs);
    return ((w / wpr) * st + t % fs) * len + (w % wpr) * st + t / fs;
  endfunction

  bit          active, done_now, done_next, was_active, hold;
  int          iss, acc, lasts, done_pulses, stall_exp;
  logic [11:0] h_addr;
  logic        h_last;
  int          s_iss, s_acc, s_lasts, s_done_pulses;
  logic [11:0] s_last_addr;

  // Per-cycle compare against the model
  always @(negedge clk_in) begin
    if (!rst_n) begin
      active = 0; done_now = 0; hold = 0;
      iss = 0; acc = 0; lasts = 0; stall_exp = 0;
    end else begin
      done_next  = 0;
      was_active = active;
      chk("frame_done", frame_done, done_now);
      if (frame_done) done_pulses++;
      chk("busy", busy, active);
      chk("mem_en", mem_en, active && (!data_valid || out_ready));
      if (!active) chk("idle_valid", data_valid, 0);
      chk("win_count", win_count, iss / 9);
`ifdef SCHED_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, stall_exp);
`else
      chk("stall_cycles", stall_cycles, 0);
`endif
      if (hold) begin
        chk("hold_valid", data_valid, 1);
        chk("hold_last", win_last, h_last);
        chk("hold_addr", pic_addr, h_addr);
      end
      hold   = data_valid && !out_ready && !abort;
      h_addr = pic_addr;
      h_last = win_last;
      if (data_valid && !out_ready) stall_exp++;
      if (active && mem_en && !abort && iss < TOTAL) begin
        chk("pic_addr", pic_addr, exp_addr(iss, 60, 3, 4));
        chk("weight_addr", weight_addr, iss % 9);
        iss++;
      end
      if (active && data_valid && out_ready && !abort) begin
        chk("win_last", win_last, (acc % 9) == 8);
        if (win_last) lasts++;
        acc++;
        if (acc == TOTAL) begin
          active    = 0;
          done_next = 1;
        end
      end
      if (abort) begin
        active = 0;
        done_next = 0;
      end else if (start && !was_active && !done_now) begin
        active = 1; iss = 0; acc = 0; lasts = 0; stall_exp = 0;
      end
      done_now = done_next;

      if (s_mem_en && s_iss < S_TOTAL) begin
        chk("small_addr", s_pic_addr, exp_addr(s_iss, 8, 3, 2));
        s_last_addr = s_pic_addr;
        s_iss++;
      end
      if (s_data_valid) begin
        s_acc++;
        if (s_win_last) s_lasts++;
      end
      if (s_frame_done) s_done_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic wait_iss(input int n);
    int c = 0;
    while (iss < n && c < 5000) begin cyc(1); c++; end
    chk("wait_iss_timeout", iss >= n, 1);
  endtask

  task automatic wait_done();
    int c = 0;
    while (!frame_done && c < 5000) begin cyc(1); c++; end
    chk("wait_done_timeout", frame_done, 1);
  endtask

  initial begin
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pic_addr", pic_addr, 0);
    chk("rst_win_count", win_count, 0);
    #20 rst_n = 1'b1;
    cyc(2);

    chk("model_first_taps", {exp_addr(0,60,3,4), exp_addr(1,60,3,4), exp_addr(2,60,3,4)}, {32'd0, 32'd60, 32'd120});
    chk("model_tap3", exp_addr(3, 60, 3, 4), 1);
    chk("model_tap8", exp_addr(8, 60, 3, 4), 122);
    chk("model_last", exp_addr(TOTAL - 1, 60, 3, 4), 3538);
    chk("model_small_last", exp_addr(S_TOTAL - 1, 8, 3, 2), 54);

    // Frame 1 with a 5-cycle mid-window stall; small instance runs alongside
    start = 1; s_start = 1; cyc(1); start = 0; s_start = 0;
    wait_iss(40);
    out_ready = 0; cyc(5); out_ready = 1;
    wait_done();
    cyc(1);
    chk("f1_beats", acc, TOTAL);
    chk("f1_last_beats", lasts, 225);
    chk("f1_win_count", win_count, 225);
    chk("f1_done_pulses", done_pulses, 1);
`ifdef SCHED_STALL_CNT_EN
    chk("f1_stall", stall_cycles, 5);
`else
    chk("f1_stall", stall_cycles, 0);
`endif
    chk("small_beats", s_acc, S_TOTAL);
    chk("small_last_beats", s_lasts, 9);
    chk("small_win_count", s_win_count, 9);
    chk("small_final_addr", s_last_addr, 54);
    chk("small_done_pulses", s_done_pulses, 1);

    // Abort inside window 100, then abort+start together, then a clean frame
    start = 1; cyc(1); start = 0;
    wait_iss(100 * 9 + 4);
    abort = 1; cyc(1); abort = 0;
    chk("abort_valid", data_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_win_count", win_count, 100);
    abort = 1; start = 1; cyc(1); abort = 0; start = 0;
    chk("abort_start_busy", busy, 0);
    cyc(3);
    chk("abort_no_done", done_pulses, 1);
    start = 1; cyc(1); start = 0;
    wait_done();
    cyc(1);
    chk("f2_beats", acc, TOTAL);
    chk("f2_win_count", win_count, 225);
    chk("f2_done_pulses", done_pulses, 2);

    // start held high through a whole frame restarts only after DONE
    start = 1;
    wait_done();
    cyc(1);
    chk("held_done_pulses", done_pulses, 3);
    cyc(1);
    start = 0;
    chk("restart_busy", busy, 1);
    chk("restart_addr", pic_addr, 0);

    // Async reset while draining
    wait_iss(TOTAL);
    chk("drain_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_en", mem_en, 0);
    chk("arst_valid", data_valid, 0);
    chk("arst_last", win_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_pic_addr", pic_addr, 0);
    chk("arst_weight", weight_addr, 0);
    chk("arst_win_count", win_count, 0);
    chk("arst_stall", stall_cycles, 0);
    #3 rst_n = 1'b1;
    cyc(3);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done_pulses", done_pulses, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
